// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key search slice.
//   KEY_W      : width of an ARC4 key
//   ASCII_MIN  : lowest printable plaintext byte
//   ASCII_MAX  : highest printable plaintext byte
//   state_t    : key search controller states (the plaintext checker reuses
//                IDLE / RD_LEN / LEN / CHK for its own phase)
//   is_printable : byte range test used by the plaintext checker
package arc4_pkg;

   localparam int         KEY_W     = 24;
   localparam logic [7:0] ASCII_MIN = 8'h20;
   localparam logic [7:0] ASCII_MAX = 8'h7E;

   typedef enum logic [3:0] {
      IDLE,
      START,
      WAIT_LO,
      WAIT_HI,
      RD_LEN,
      LEN,
      CHK,
      NEXT,
      DONE
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= ASCII_MIN) && (b <= ASCII_MAX);
   endfunction

endpackage

// File: rtl/pt_checker.sv
// Plaintext scanner: after a start pulse, reads the length byte at address 0,
// then checks bytes 1..L one per cycle against the printable ASCII range.
// Ends with a one-cycle done pulse; pass qualifies done.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a scan (single cycle, only honoured while idle)
//   pt_rddata     : plaintext read data, one cycle after pt_addr
//   pt_sel        : high while the scanner owns the plaintext port
//   pt_addr       : plaintext read address
//   done, pass    : scan finished / all bytes printable (or L = 0)
//
// phase   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start, port released
// RD_LEN  | presenting address 0
// LEN     | length byte on pt_rddata, presenting address 1
// CHK     | byte idx on pt_rddata, presenting address idx+1
module pt_checker
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] pt_rddata,
   output logic       pt_sel,
   output logic [7:0] pt_addr,
   output logic       done,
   output logic       pass
);

   state_t     phase_q, phase_d;
   logic [7:0] len_q, len_d;
   logic [7:0] idx_q, idx_d;
   logic       byte_ok;

   assign byte_ok = is_printable(pt_rddata);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= IDLE;
         len_q   <= 8'd0;
         idx_q   <= 8'd0;
      end else begin
         phase_q <= phase_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      len_d   = len_q;
      idx_d   = idx_q;
      case (phase_q)
         IDLE: begin
            if (start) phase_d = RD_LEN;
         end
         RD_LEN: begin
            phase_d = LEN;
         end
         LEN: begin
            if (pt_rddata == 8'd0) begin
               phase_d = IDLE;
            end else begin
               len_d   = pt_rddata;
               idx_d   = 8'd1;
               phase_d = CHK;
            end
         end
         CHK: begin
            if (!byte_ok || (idx_q == len_q)) phase_d = IDLE;
            else                              idx_d   = idx_q + 8'd1;
         end
         default: phase_d = IDLE;
      endcase
   end

   always_comb begin
      pt_sel  = 1'b0;
      pt_addr = 8'd0;
      done    = 1'b0;
      pass    = 1'b0;
      case (phase_q)
         RD_LEN: begin
            pt_sel = 1'b1;
         end
         LEN: begin
            pt_sel  = 1'b1;
            pt_addr = 8'd1;
            // An empty message is trivially printable.
            if (pt_rddata == 8'd0) begin
               done = 1'b1;
               pass = 1'b1;
            end
         end
         CHK: begin
            pt_sel  = 1'b1;
            pt_addr = idx_q + 8'd1;
            if (!byte_ok) begin
               done = 1'b1;
            end else if (idx_q == len_q) begin
               done = 1'b1;
               pass = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/key_search.sv
// Brute-force ARC4 key search controller. Steps a key from KEY_FIRST by
// KEY_STEP, runs the arc4 decryptor for each key and hands the plaintext to
// pt_checker; stops at the first key whose plaintext is printable or when the
// key would pass 24'hFFFFFF.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : start request, honoured only while rdy
//   rdy                : idle or done
//   key                : key presented to arc4
//   a4_en, a4_rdy      : arc4 start pulse / arc4 ready
//   pt_sel, pt_addr    : plaintext port ownership and address
//   pt_rddata          : plaintext read data (one-cycle latency)
//   key_valid          : a key was found (held in DONE)
//   found_key          : the key that was found
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for en
// START   | a4_en pulse for the current key
// WAIT_LO | waiting for arc4 to drop a4_rdy
// WAIT_HI | waiting for arc4 to finish
// RD_LEN  | checker reading the length byte address
// LEN     | checker capturing the length
// CHK     | checker scanning plaintext bytes
// NEXT    | step key or give up on overflow
// DONE    | result held, waiting for en
module key_search
   import arc4_pkg::*;
#(
   parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
   parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             rdy,
   output logic [KEY_W-1:0] key,
   output logic             a4_en,
   input  logic             a4_rdy,
   output logic             pt_sel,
   output logic [7:0]       pt_addr,
   input  logic [7:0]       pt_rddata,
   output logic             key_valid,
   output logic [KEY_W-1:0] found_key
);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] found_key_q;
   logic             key_valid_q;
   logic [KEY_W:0]   key_sum;
   logic             chk_start;
   logic             chk_done;
   logic             chk_pass;

   // Carry bit of the 25-bit sum flags that the key space is exhausted.
   assign key_sum   = {1'b0, key_q} + {1'b0, KEY_STEP};
   assign chk_start = (state_q == WAIT_HI) && a4_rdy;

   // The checker leaves its idle phase on the same edge this FSM enters
   // RD_LEN, so RD_LEN/LEN/CHK here track the checker's phase cycle for cycle.
   pt_checker u_pt_checker (
      .clk       (clk),
      .rst       (rst),
      .start     (chk_start),
      .pt_rddata (pt_rddata),
      .pt_sel    (pt_sel),
      .pt_addr   (pt_addr),
      .done      (chk_done),
      .pass      (chk_pass)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (en) state_d = START;
         end
         START: begin
            state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!a4_rdy) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (a4_rdy) state_d = RD_LEN;
         end
         RD_LEN: begin
            state_d = LEN;
         end
         LEN, CHK: begin
            if (chk_done) state_d = chk_pass ? DONE : NEXT;
            else          state_d = CHK;
         end
         NEXT: begin
            state_d = key_sum[KEY_W] ? DONE : START;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdy   = (state_q == IDLE) || (state_q == DONE);
      a4_en = (state_q == START);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q       <= KEY_FIRST;
         key_valid_q <= 1'b0;
         found_key_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (en) begin
                  key_q       <= KEY_FIRST;
                  key_valid_q <= 1'b0;
               end
            end
            LEN, CHK: begin
               if (chk_done && chk_pass) begin
                  key_valid_q <= 1'b1;
                  found_key_q <= key_q;
               end
            end
            NEXT: begin
               if (!key_sum[KEY_W]) key_q <= key_sum[KEY_W-1:0];
            end
            default: ;
         endcase
      end
   end

   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign found_key = found_key_q;

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: two instances (default parameters, and
// KEY_FIRST=FFFFFD / KEY_STEP=2), each with an arc4 + plaintext memory model.
// A reference model derives the expected key sequence, per-attempt scan length
// and final result from the plaintext rules; a negedge monitor compares.
module tb_key_search;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        en  [2];
   logic [1:0]  rdy, a4_en, pt_sel, key_valid;
   logic [23:0] key [2];
   logic [23:0] found_key [2];
   logic [7:0]  pt_addr [2];
   logic [7:0]  pt_rddata [2];
   logic        a4_rdy [2] = '{1'b1, 1'b1};

   int          cnt  [2] = '{0, 0};
   logic [23:0] kcap [2];
   logic [7:0]  mem  [2][256];
   int          mode [2] = '{9, 9};
   bit          hold [2] = '{1'b0, 1'b0};
   bit          mon_on [2] = '{1'b0, 1'b0};

   int          exp_n [2];
   logic [23:0] exp_key [2][16];
   int          exp_sel [2][16];
   bit          exp_valid [2];
   logic [23:0] exp_found [2];

   int          att_idx [2];
   int          sel_cnt [2];
   bit          prev_sel [2];
   bit          prev_a4 [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_search #(.KEY_FIRST(24'h000000), .KEY_STEP(24'h000001)) dut0 (
      .clk(clk), .rst(rst[0]), .en(en[0]), .rdy(rdy[0]), .key(key[0]),
      .a4_en(a4_en[0]), .a4_rdy(a4_rdy[0]), .pt_sel(pt_sel[0]),
      .pt_addr(pt_addr[0]), .pt_rddata(pt_rddata[0]),
      .key_valid(key_valid[0]), .found_key(found_key[0]));

   key_search #(.KEY_FIRST(24'hFFFFFD), .KEY_STEP(24'h000002)) dut1 (
      .clk(clk), .rst(rst[1]), .en(en[1]), .rdy(rdy[1]), .key(key[1]),
      .a4_en(a4_en[1]), .a4_rdy(a4_rdy[1]), .pt_sel(pt_sel[1]),
      .pt_addr(pt_addr[1]), .pt_rddata(pt_rddata[1]),
      .key_valid(key_valid[1]), .found_key(found_key[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Plaintext produced by the arc4 model for a given scenario and key.
   function automatic logic [7:0] pt_byte(input int m, input logic [23:0] k, input int i);
      logic [7:0] b;
      b = 8'h00;
      case (m)
         0: begin
            if (k == 24'h000003) begin
               case (i)
                  0: b = 8'd3;
                  1: b = 8'h41;
                  2: b = 8'h42;
                  3: b = 8'h43;
                  default: b = 8'h00;
               endcase
            end else b = 8'h01;
         end
         1: begin
            case (i)
               0: b = 8'd2;
               1: b = 8'h20;
               2: b = 8'h7E;
               default: b = 8'h00;
            endcase
         end
         2: begin
            if (k == 24'h0) begin
               case (i) 0: b = 8'd2; 1: b = 8'h41; 2: b = 8'h1F; default: b = 8'h00; endcase
            end else if (k == 24'h1) begin
               case (i) 0: b = 8'd2; 1: b = 8'h7F; 2: b = 8'h41; default: b = 8'h00; endcase
            end else begin
               case (i) 0: b = 8'd1; 1: b = 8'h5A; default: b = 8'h00; endcase
            end
         end
         3: b = 8'h00;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

   task automatic build_model(input int g, input int m);
      logic [23:0] k;
      logic [24:0] s;
      int          n, len, stop;
      bit          ok, fin;
      k   = (g == 0) ? 24'h000000 : 24'hFFFFFD;
      n   = 0;
      fin = 0;
      exp_valid[g] = 0;
      exp_found[g] = 24'h0;
      while (!fin && n < 16) begin
         exp_key[g][n] = k;
         len  = int'(pt_byte(m, k, 0));
         ok   = 1;
         stop = len;
         for (int i = 1; i <= len; i++) begin
            if (ok && (pt_byte(m, k, i) < 8'h20 || pt_byte(m, k, i) > 8'h7E)) begin
               ok   = 0;
               stop = i;
            end
         end
         exp_sel[g][n] = stop + 2;
         n++;
         if (ok) begin
            exp_valid[g] = 1;
            exp_found[g] = k;
            fin = 1;
         end else begin
            s = {1'b0, k} + ((g == 0) ? 25'd1 : 25'd2);
            if (s > 25'h0FFFFFF) fin = 1;
            else k = s[23:0];
         end
      end
      exp_n[g] = n;
   endtask

   // arc4 + plaintext memory model
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (a4_en[g]) begin
            a4_rdy[g] <= 1'b0;
            cnt[g]    <= 3 + g;
            kcap[g]   <= key[g];
         end else if (cnt[g] > 0 && !hold[g]) begin
            cnt[g] <= cnt[g] - 1;
            if (cnt[g] == 1) begin
               a4_rdy[g] <= 1'b1;
               for (int i = 0; i < 256; i++) mem[g][i] <= pt_byte(mode[g], kcap[g], i);
            end
         end
         pt_rddata[g] <= mem[g][pt_addr[g]];
      end
   end

   // compare process
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!mon_on[g]) begin
            att_idx[g]  = 0;
            sel_cnt[g]  = 0;
            prev_sel[g] = 0;
            prev_a4[g]  = 0;
         end else begin
            if (rdy[g]) chk("idle_quiet", {30'b0, a4_en[g], pt_sel[g]}, 32'd0);
            if (a4_en[g]) begin
               chk("a4_en_width", {31'b0, prev_a4[g]}, 32'd0);
               if (att_idx[g] < exp_n[g])
                  chk("attempt_key", {8'h0, key[g]}, {8'h0, exp_key[g][att_idx[g]]});
               else
                  chk("attempt_count", att_idx[g] + 1, exp_n[g]);
               att_idx[g]++;
            end
            if (pt_sel[g]) sel_cnt[g]++;
            else if (prev_sel[g]) begin
               if (att_idx[g] > 0 && att_idx[g] <= exp_n[g])
                  chk("scan_cycles", sel_cnt[g], exp_sel[g][att_idx[g]-1]);
               sel_cnt[g] = 0;
            end
            prev_sel[g] = pt_sel[g];
            prev_a4[g]  = a4_en[g];
         end
      end
   end

   task automatic run_search(input int g, input int m, input bit inj);
      int          t;
      logic [23:0] kb;
      build_model(g, m);
      mode[g] = m;
      @(posedge clk); #1;
      mon_on[g] = 1;
      en[g]     = 1;
      @(posedge clk); #1;
      en[g] = 0;
      if (inj) begin
         t = 0;
         do begin @(negedge clk); t++; end while (!pt_sel[g] && t < 500);
         chk("scan_timeout", {31'b0, pt_sel[g]}, 32'd1);
         repeat (2) @(negedge clk);
         kb    = key[g];
         en[g] = 1;
         @(posedge clk); #1;
         en[g] = 0;
         chk("en_in_chk_key", {8'h0, key[g]}, {8'h0, kb});
         chk("en_in_chk_busy", {31'b0, rdy[g]}, 32'd0);
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!rdy[g] && t < 3000);
      chk("done_timeout", {31'b0, rdy[g]}, 32'd1);
      @(posedge clk); #1;
      chk("attempts", att_idx[g], exp_n[g]);
      chk("key_valid", {31'b0, key_valid[g]}, {31'b0, exp_valid[g]});
      if (exp_valid[g]) chk("found_key", {8'h0, found_key[g]}, {8'h0, exp_found[g]});
      chk("rdy_done", {31'b0, rdy[g]}, 32'd1);
      mon_on[g] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst[0] = 1; rst[1] = 1; en[0] = 0; en[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy",       {30'b0, rdy},       32'd3);
      chk("rst_a4_en",     {30'b0, a4_en},     32'd0);
      chk("rst_pt_sel",    {30'b0, pt_sel},    32'd0);
      chk("rst_key_valid", {30'b0, key_valid}, 32'd0);
      chk("rst_key0",      {8'h0, key[0]},     32'h000000);
      chk("rst_key1",      {8'h0, key[1]},     32'hFFFFFD);
      chk("rst_found0",    {8'h0, found_key[0]}, 32'h0);
      chk("rst_pt_addr0",  {24'h0, pt_addr[0]},  32'h0);
      rst[0] = 0; rst[1] = 0;

      // four attempts, key 3 found
      run_search(0, 0, 0);
      chk("m0_pulses_lit", att_idx[0], 32'd4);
      chk("m0_found_lit",  {8'h0, found_key[0]}, 32'h000003);
      // restart from DONE
      run_search(0, 0, 0);
      chk("m0r_pulses_lit", att_idx[0], 32'd4);
      // 0x20 / 0x7E boundaries accepted
      run_search(0, 1, 0);
      chk("m1_found_lit", {8'h0, found_key[0]}, 32'h000000);
      // 0x1F and 0x7F rejected, en during CHK ignored
      run_search(0, 2, 1);
      chk("m2_pulses_lit", att_idx[0], 32'd3);
      chk("m2_found_lit",  {8'h0, found_key[0]}, 32'h000002);
      // empty message
      run_search(0, 3, 0);
      chk("m3_pulses_lit", att_idx[0], 32'd1);
      // key space exhaustion
      run_search(1, 4, 0);
      chk("m4_pulses_lit", att_idx[1], 32'd2);
      chk("m4_valid_lit",  {31'b0, key_valid[1]}, 32'd0);
      chk("m4_key_lit",    {8'h0, key[1]}, 32'hFFFFFF);

      // reset wins over en
      @(posedge clk); #1;
      rst[0] = 1; en[0] = 1;
      @(posedge clk); #1;
      rst[0] = 0; en[0] = 0;
      @(posedge clk); #1;
      chk("rst_pri_rdy",   {31'b0, rdy[0]},   32'd1);
      chk("rst_pri_a4_en", {31'b0, a4_en[0]}, 32'd0);

      // reset while waiting for arc4 to finish
      mode[0] = 1;
      hold[0] = 1;
      en[0]   = 1;
      @(posedge clk); #1;
      en[0] = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("wait_hi_busy", {31'b0, rdy[0]}, 32'd0);
      chk("wait_hi_a4rdy", {31'b0, a4_rdy[0]}, 32'd0);
      rst[0] = 1;
      @(posedge clk); #1;
      rst[0] = 0;
      chk("mid_rst_rdy",    {31'b0, rdy[0]},       32'd1);
      chk("mid_rst_a4_en",  {31'b0, a4_en[0]},     32'd0);
      chk("mid_rst_pt_sel", {31'b0, pt_sel[0]},    32'd0);
      chk("mid_rst_key",    {8'h0, key[0]},        32'h0);
      chk("mid_rst_valid",  {31'b0, key_valid[0]}, 32'd0);
      chk("mid_rst_found",  {8'h0, found_key[0]},  32'h0);
      hold[0] = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_idle", {31'b0, rdy[0]},    32'd1);
      chk("post_rst_sel",  {31'b0, pt_sel[0]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_search.md
KEY_SEARCH -- requirements
Module: key_search

Interface
REQ-001 Parameter KEY_FIRST, 24'h000000, first key tried after each start.
REQ-002 Parameter KEY_STEP, 24'h000001, key increment between attempts (KEY_STEP=2 lets two searchers split the space).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 en  in  1  start request, sampled only while rdy=1.
REQ-006 rdy  out  1  high when idle or done; start accepted.
REQ-007 key  out  24  key currently presented to the arc4 decryptor.
REQ-008 a4_en  out  1  one-cycle start pulse to arc4.
REQ-009 a4_rdy  in  1  arc4 ready; drops after a4_en, rises on completion.
REQ-010 pt_sel  out  1  1 = key_search owns the plaintext memory port, 0 = arc4 owns it.
REQ-011 pt_addr  out  8  plaintext read address, valid when pt_sel=1.
REQ-012 pt_rddata  in  8  plaintext read data, one-cycle latency after pt_addr.
REQ-013 key_valid  out  1  high in DONE when a key was found.
REQ-014 found_key  out  24  matching key, valid when key_valid=1.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_LO, WAIT_HI, RD_LEN, LEN, CHK, NEXT, DONE.
REQ-016 IDLE: rdy=1; en=1 -> key<=KEY_FIRST, key_valid<=0, go START.
REQ-017 START: a4_en=1 for exactly one cycle, go WAIT_LO.
REQ-018 WAIT_LO: stay until a4_rdy=0, then WAIT_HI; WAIT_HI: stay until a4_rdy=1, then RD_LEN.
REQ-019 pt_sel SHALL be 1 only in RD_LEN, LEN, CHK; 0 otherwise.
REQ-020 RD_LEN: pt_addr=0, go LEN; LEN: capture L=pt_rddata, pt_addr=1, go CHK (or go DONE found if L=0).
REQ-021 CHK: each cycle check byte i (i=1..L) from pt_rddata while presenting pt_addr=i+1; one byte per cycle, scan of L bytes takes L+2 cycles from RD_LEN.
REQ-022 Byte valid iff 8'h20 <= byte <= 8'h7E inclusive; first invalid byte -> NEXT immediately.
REQ-023 Byte i=L valid -> DONE with key_valid=1, found_key=key.
REQ-024 NEXT: sum = {1'b0,key}+KEY_STEP in 25 bits; sum > 24'hFFFFFF -> DONE with key_valid=0; else key<=sum[23:0], go START.
REQ-025 DONE: rdy=1, key_valid and found_key held; en=1 restarts exactly as from IDLE.
REQ-026 en while rdy=0 SHALL be ignored.
REQ-027 a4_en SHALL never be asserted outside START.

Reset
REQ-028 rst=1 SHALL force IDLE, rdy=1, a4_en=0, pt_sel=0, pt_addr=0, key=KEY_FIRST, key_valid=0, found_key=0, from any state including mid-scan or WAIT_HI.
REQ-029 rst SHALL take priority over en in the same cycle.

Structure
REQ-030 Package arc4_pkg SHALL hold the state enum, KEY_W=24, ASCII_MIN=8'h20, ASCII_MAX=8'h7E.
REQ-031 One sub-module, pt_checker, SHALL implement RD_LEN/LEN/CHK scanning with start/done/pass handshake; key stepping and arc4 handshake remain in key_search.

Verification
REQ-032 rst high 2 cycles -> rdy=1, a4_en=0, key=0, key_valid=0, pt_sel=0.
REQ-033 arc4 model yields L=3 "ABC" for key 24'h000003, byte 0x01 otherwise; pulse en -> exactly 4 a4_en pulses, key_valid=1, found_key=24'h000003.
REQ-034 Boundaries: pt {L=2, 0x20, 0x7E} -> found; pt {L=2, 0x41, 0x1F} and {L=2, 0x7F, 0x41} -> rejected, NEXT.
REQ-035 pt L=0 for every key -> found at KEY_FIRST after one a4_en pulse.
REQ-036 KEY_FIRST=24'hFFFFFD, KEY_STEP=2, all plaintext invalid -> keys FFFFFD then FFFFFF tried, then DONE, key_valid=0, rdy=1.
REQ-037 rst asserted in WAIT_HI -> IDLE next cycle; en asserted in CHK -> no effect on key or state.
